// File: rtl/seg_scan_capture_pkg.sv
// Shared types and constants for the seven-segment scan capture block.
package seg_scan_capture_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHeld
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry i is the gfedcba pattern for hex digit i (index 15 first).
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to hex nibble decoder with blank/dp/bad flags.
module seg7_decode
    import seg_scan_capture_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       dp,
    output logic       bad
);

    logic hit;

    always_comb begin
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg[6:0] == SEG_HEX[i]) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end

    assign blank = (seg[6:0] == SEG_BLANK);
    assign dp    = seg[7];
    assign bad   = !hit && !blank;

endmodule

// File: rtl/seg_scan_capture.sv
// Rebuilds the displayed frame from a multiplexed 8-digit seven-segment scan.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned TIMEOUT        = 1000,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [7:0]  dig,
    output logic [31:0] code,
    output logic [7:0]  blank,
    output logic [7:0]  dp,
    output logic [7:0]  bad,
    output logic        frame_valid,
    output logic [15:0] frame_cnt,
    output logic        dig_err,
    output logic        stale
);

    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    // Input register resets to "nothing selected" so reset is not seen as multi-hot.
    localparam logic [7:0] DIG_IDLE = DIG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0]    seg_q, dig_q, prev_seg_q, prev_sel_q, sel;
    logic          multi, onehot, same, capture, complete;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [31:0]   shd_code_q, shd_code_d, code_q;
    logic [7:0]    shd_blank_q, shd_blank_d, shd_dp_q, shd_dp_d, shd_bad_q, shd_bad_d;
    logic [7:0]    blank_q, dp_q, bad_q, mask_q, mask_d;
    logic          fv_q, dig_err_q, stale_q;
    logic [15:0]   frame_cnt_q;
    logic [3:0]    dec_nibble;
    logic          dec_blank, dec_dp, dec_bad;

    assign sel    = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
    assign multi  = |(sel & (sel - 8'd1));
    assign onehot = (sel != 8'h00) && !multi;
    assign same   = (sel == prev_sel_q) && (seg_q == prev_seg_q);

    seg7_decode u_dec (
        .seg    (seg_q),
        .nibble (dec_nibble),
        .blank  (dec_blank),
        .dp     (dec_dp),
        .bad    (dec_bad)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!onehot) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StSettle;
                    cnt_d   = CW'(1);
                end
                StSettle: begin
                    if (!same) begin
                        cnt_d = CW'(1);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(SETTLE - 1)) state_d = StHeld;
                    end
                end
                StHeld: begin
                    if (!same) begin
                        state_d = StSettle;
                        cnt_d   = CW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        capture = onehot && (state_q == StSettle) && same && (cnt_q == CW'(SETTLE - 1));
    end

    always_comb begin
        shd_code_d  = shd_code_q;
        shd_blank_d = shd_blank_q;
        shd_dp_d    = shd_dp_q;
        shd_bad_d   = shd_bad_q;
        mask_d      = mask_q;
        complete    = 1'b0;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    shd_code_d[4*i +: 4] = dec_nibble;
                    shd_blank_d[i]       = dec_blank;
                    shd_dp_d[i]          = dec_dp;
                    shd_bad_d[i]         = dec_bad;
                end
            end
            if ((mask_q | sel) == 8'hFF) begin
                mask_d   = 8'h00;
                complete = 1'b1;
            end else begin
                mask_d = mask_q | sel;
            end
        end
        if (capture) idle_d = '0;
        else if (idle_q == IW'(TIMEOUT)) idle_d = idle_q;
        else idle_d = idle_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q       <= 8'h00;
            dig_q       <= DIG_IDLE;
            prev_seg_q  <= 8'h00;
            prev_sel_q  <= 8'h00;
            shd_code_q  <= '0;
            shd_blank_q <= '0;
            shd_dp_q    <= '0;
            shd_bad_q   <= '0;
            mask_q      <= '0;
            idle_q      <= '0;
            code_q      <= '0;
            blank_q     <= '0;
            dp_q        <= '0;
            bad_q       <= '0;
            fv_q        <= 1'b0;
            frame_cnt_q <= '0;
            dig_err_q   <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            seg_q       <= seg;
            dig_q       <= dig;
            prev_seg_q  <= seg_q;
            prev_sel_q  <= sel;
            shd_code_q  <= shd_code_d;
            shd_blank_q <= shd_blank_d;
            shd_dp_q    <= shd_dp_d;
            shd_bad_q   <= shd_bad_d;
            mask_q      <= mask_d;
            idle_q      <= idle_d;
            fv_q        <= complete;
            dig_err_q   <= dig_err_q | multi;
            if (complete) begin
                code_q      <= shd_code_d;
                blank_q     <= shd_blank_d;
                dp_q        <= shd_dp_d;
                bad_q       <= shd_bad_d;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                stale_q     <= 1'b0;
            end else if (idle_d == IW'(TIMEOUT)) begin
                stale_q <= 1'b1;
            end
        end
    end

    assign code        = code_q;
    assign blank       = blank_q;
    assign dp          = dp_q;
    assign bad         = bad_q;
    assign frame_valid = fv_q;
    assign frame_cnt   = frame_cnt_q;
    assign dig_err     = dig_err_q;
    assign stale       = stale_q;

endmodule
